// File: rtl/sisc_pkg.sv
// Shared SISC definitions: controller state encoding, opcode values and datapath select codes.
package sisc_pkg;

    typedef enum logic [2:0] {
        ST_START   = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_MEM     = 3'd4,
        ST_WB      = 3'd5,
        ST_HALT    = 3'd6
    } state_e;

    // Decoded instruction class; any unlisted opcode maps to I_NOOP.
    typedef enum logic [3:0] {
        I_NOOP, I_LOD, I_STR, I_SWP, I_BRA, I_BRR, I_BNE, I_BNR, I_ALU, I_HLT
    } instr_e;

    localparam int unsigned OP_NOOP = 0;
    localparam int unsigned OP_LOD  = 1;
    localparam int unsigned OP_STR  = 2;
    localparam int unsigned OP_SWP  = 3;
    localparam int unsigned OP_BRA  = 4;
    localparam int unsigned OP_BRR  = 5;
    localparam int unsigned OP_BNE  = 6;
    localparam int unsigned OP_BNR  = 7;
    localparam int unsigned OP_ALU  = 8;

    // mm value selecting the immediate operand.
    localparam int unsigned MM_IMM  = 8;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_IMM  = 2'b01;
    localparam logic [1:0] ALU_PASS = 2'b10;

    localparam logic [1:0] WB_ALU    = 2'b00;
    localparam logic [1:0] WB_MEM    = 2'b01;
    localparam logic [1:0] WB_SWAP_B = 2'b10;
    localparam logic [1:0] WB_SWAP_A = 2'b11;

    // HLT is the all-ones opcode, so it tracks the opcode width.
    function automatic int unsigned op_hlt(input int unsigned opw);
        return (32'd1 << opw) - 32'd1;
    endfunction

endpackage

// File: rtl/sisc_br_eval.sv
// Branch decision: hit when any masked status bit is set; the negated forms take on a miss.
module sisc_br_eval #(
    parameter int CCW = 4
) (
    input  logic [CCW-1:0] mm,
    input  logic [CCW-1:0] stat,
    input  logic           negate,
    output logic           taken
);

    assign taken = (|(mm & stat)) ^ negate;

endmodule

// File: rtl/sisc_ctrl_v2.sv
// SISC multi-cycle controller: fetch/decode/execute/mem/writeback sequencing with a
// bounded memory-wait timeout that parks the core in HALT with err set.
module sisc_ctrl_v2
    import sisc_pkg::*;
#(
    parameter int OPW      = 4,
    parameter int CCW      = 4,
    parameter int WAIT_MAX = 15
) (
    input  logic           clk,
    input  logic           rst_f,
    input  logic [OPW-1:0] opcode,
    input  logic [CCW-1:0] mm,
    input  logic [CCW-1:0] stat,
    input  logic           mem_rdy,
    output logic           mem_req,
    output logic           rf_we,
    output logic           ir_load,
    output logic           pc_write,
    output logic           pc_sel,
    output logic           br_sel,
    output logic           rb_sel,
    output logic           mm_sel,
    output logic           dm_we,
    output logic           wr_sel,
    output logic           pc_rst,
    output logic [1:0]     alu_op,
    output logic [1:0]     wb_sel,
    output logic           halted,
    output logic           err
);

    localparam logic [OPW-1:0] HLT_CODE  = OPW'(op_hlt(OPW));
    localparam logic [7:0]     WAIT_LAST = 8'(WAIT_MAX - 1);

    state_e     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       err_q, err_d;
    logic       start_armed_q;

    instr_e     instr;
    logic       is_branch;
    logic       is_mem_op;
    logic       br_taken;
    logic       wait_last;

    always_comb begin
        instr = I_NOOP;
        if      (opcode == OPW'(OP_LOD)) instr = I_LOD;
        else if (opcode == OPW'(OP_STR)) instr = I_STR;
        else if (opcode == OPW'(OP_SWP)) instr = I_SWP;
        else if (opcode == OPW'(OP_BRA)) instr = I_BRA;
        else if (opcode == OPW'(OP_BRR)) instr = I_BRR;
        else if (opcode == OPW'(OP_BNE)) instr = I_BNE;
        else if (opcode == OPW'(OP_BNR)) instr = I_BNR;
        else if (opcode == OPW'(OP_ALU)) instr = I_ALU;
        else if (opcode == HLT_CODE)     instr = I_HLT;
    end

    assign is_branch = (instr == I_BRA) || (instr == I_BRR) || (instr == I_BNE) || (instr == I_BNR);
    assign is_mem_op = (instr == I_LOD) || (instr == I_STR);
    assign wait_last = (wait_cnt_q == WAIT_LAST);

    sisc_br_eval #(.CCW(CCW)) u_br_eval (
        .mm     (mm),
        .stat   (stat),
        .negate ((instr == I_BNE) || (instr == I_BNR)),
        .taken  (br_taken)
    );

    // NOTE: every output and next-state value gets a default before the case, so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        mem_req  = 1'b0;
        rf_we    = 1'b0;
        ir_load  = 1'b0;
        pc_write = 1'b0;
        pc_sel   = 1'b0;
        br_sel   = 1'b0;
        rb_sel   = 1'b0;
        mm_sel   = 1'b1;
        dm_we    = 1'b0;
        wr_sel   = 1'b0;
        pc_rst   = 1'b0;
        alu_op   = ALU_PASS;
        wb_sel   = WB_ALU;
        halted   = 1'b0;

        unique case (state_q)
            ST_START: begin
                pc_rst = 1'b1;
                // One extra START cycle after reset release before the first fetch.
                if (start_armed_q) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_rdy) begin
                    ir_load  = 1'b1;
                    pc_write = 1'b1;
                    state_d  = ST_DECODE;
                end else if (wait_last) begin
                    state_d = ST_HALT;
                end
            end
            ST_DECODE: begin
                rb_sel = (instr == I_STR) || (instr == I_SWP);
                br_sel = (instr == I_BRA) || (instr == I_BNE);
                if (is_branch && br_taken) begin
                    pc_sel   = 1'b1;
                    pc_write = 1'b1;
                end
                state_d = (instr == I_HLT) ? ST_HALT : ST_EXECUTE;
            end
            ST_EXECUTE: begin
                if (is_mem_op || instr == I_ALU)
                    alu_op = (mm == CCW'(MM_IMM)) ? ALU_IMM : ALU_ADD;
                mm_sel  = (mm == '0);
                state_d = ST_MEM;
            end
            ST_MEM: begin
                if (is_mem_op) begin
                    mem_req = 1'b1;
                    if (instr == I_LOD) wb_sel = WB_MEM;
                    if (mem_rdy) begin
                        dm_we   = (instr == I_STR);
                        state_d = ST_WB;
                    end else if (wait_last) begin
                        state_d = ST_HALT;
                    end
                end else begin
                    if (instr == I_SWP) begin
                        wr_sel = 1'b1;
                        wb_sel = WB_SWAP_A;
                        rf_we  = 1'b1;
                    end
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                if (instr == I_LOD) begin
                    wb_sel = WB_MEM;
                    rf_we  = 1'b1;
                end else if (instr == I_ALU) begin
                    rf_we = 1'b1;
                end else if (instr == I_SWP) begin
                    wb_sel = WB_SWAP_B;
                    rf_we  = 1'b1;
                end
                state_d = ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: state_d = ST_START;
        endcase

        // Counter restarts on every state change and on a completed access.
        wait_cnt_d = wait_cnt_q;
        if (state_d != state_q)
            wait_cnt_d = '0;
        else if (mem_req)
            wait_cnt_d = mem_rdy ? 8'd0 : wait_cnt_q + 8'd1;

        err_d = err_q | (mem_req && !mem_rdy && wait_last);
    end

    assign err = err_q;

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q       <= ST_START;
            wait_cnt_q    <= '0;
            err_q         <= 1'b0;
            start_armed_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            err_q         <= err_d;
            start_armed_q <= 1'b1;
        end
    end

endmodule
